// File: rtl/sd_ram_pkg.sv
// Shared types and constants for the SD-stream-to-RAM writer.
// The byte packer, the interface and the top level all import this package.
package sd_ram_pkg;

    // Control states of the writer.
    //   IDLE  : waiting for a start command
    //   FILL  : accepting stream bytes into the word being packed
    //   WRITE : presenting a packed word to the RAM until a clock-enabled cycle
    //   DONE  : one-cycle end-of-transfer marker
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } sd_wr_state_t;

    // A RAM word is SD_LANES byte lanes of SD_LANE_W bits, little-endian.
    localparam int SD_LANES      = 4;
    localparam int SD_LANE_W     = 8;
    localparam int SD_WORD_W     = SD_LANES * SD_LANE_W;
    localparam int SD_LANE_IDX_W = $clog2(SD_LANES);

    // One-hot byte-enable bit for a lane index.
    function automatic logic [SD_LANES-1:0] lane_onehot(input logic [SD_LANE_IDX_W-1:0] lane);
        logic [SD_LANES-1:0] mask;
        mask       = '0;
        mask[lane] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/sd_stream_ram_writer_if.sv
// Bundle of the writer's command, stream, RAM-write and status signals.
//
// Handshake rules:
//   Stream : a byte moves on every rising clk edge where s_valid and s_ready
//            are both 1.  s_ready does not depend on s_valid.  The source
//            holds s_data stable while s_valid=1 and s_ready=0.
//   RAM    : while mem_write=1 the address, byteenable and writedata stay
//            stable; the write completes on the first edge with mem_clken=1,
//            and exactly once per packed word.
//   Command: start is looked at only while the writer is idle; base_addr and
//            byte_len are captured on the same edge.
interface sd_stream_ram_writer_if #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 19
);
    import sd_ram_pkg::*;

    // Command
    logic                      start;
    logic [ADDR_W-1:0]         base_addr;
    logic [LEN_W-1:0]          byte_len;

    // Byte stream
    logic [SD_LANE_W-1:0]      s_data;
    logic                      s_valid;
    logic                      s_ready;

    // RAM write port
    logic                      mem_clken;
    logic                      mem_chipselect;
    logic                      mem_write;
    logic [ADDR_W-1:0]         mem_address;
    logic [SD_LANES-1:0]       mem_byteenable;
    logic [SD_WORD_W-1:0]      mem_writedata;

    // Status
    logic                      busy;
    logic                      done;
    logic [ADDR_W:0]           words_written;
    sd_wr_state_t              dbg_state;

    // The writer block itself.
    modport slave (
        input  start, base_addr, byte_len,
        input  s_data, s_valid,
        output s_ready,
        input  mem_clken,
        output mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata,
        output busy, done, words_written, dbg_state
    );

    // Whatever issues commands, sources bytes and owns the RAM clock enable.
    modport master (
        output start, base_addr, byte_len,
        output s_data, s_valid,
        input  s_ready,
        output mem_clken,
        input  mem_chipselect, mem_write, mem_address, mem_byteenable, mem_writedata,
        input  busy, done, words_written, dbg_state
    );

endinterface

// File: rtl/sd_byte_packer.sv
// Little-endian byte-to-word packer.
// Accepted bytes land in the next free lane of the word register and set the
// matching byteenable bit. clear_i empties the word after the RAM has taken it,
// so lanes that were never filled always read as zero.
module sd_byte_packer
    import sd_ram_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 accept_i,   // a stream byte is taken this cycle
    input  logic [SD_LANE_W-1:0] data_i,     // the byte being taken
    input  logic                 last_i,     // this byte is the last of the transfer
    input  logic                 clear_i,    // RAM write completes this cycle
    output logic                 full_o,     // next accepted byte fills the top lane
    output logic                 flush_o,    // word is ready for the RAM after this edge
    output logic [SD_WORD_W-1:0] wdata_o,
    output logic [SD_LANES-1:0]  byteen_o
);

    localparam logic [SD_LANE_IDX_W-1:0] TOP_LANE = SD_LANE_IDX_W'(SD_LANES - 1);

    logic [SD_LANE_IDX_W-1:0] lane_q,   lane_d;
    logic [SD_WORD_W-1:0]     wdata_q,  wdata_d;
    logic [SD_LANES-1:0]      byteen_q, byteen_d;

    // Next lane/word/byteenable: clear has priority, then byte insertion.
    always_comb begin
        lane_d   = lane_q;
        wdata_d  = wdata_q;
        byteen_d = byteen_q;
        if (clear_i) begin
            lane_d   = '0;
            wdata_d  = '0;
            byteen_d = '0;
        end else if (accept_i) begin
            wdata_d[lane_q*SD_LANE_W +: SD_LANE_W] = data_i;
            byteen_d = byteen_q | lane_onehot(lane_q);
            lane_d   = lane_q + SD_LANE_IDX_W'(1);
        end
    end

    // Lane counter and word accumulation registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q   <= '0;
            wdata_q  <= '0;
            byteen_q <= '0;
        end else begin
            lane_q   <= lane_d;
            wdata_q  <= wdata_d;
            byteen_q <= byteen_d;
        end
    end

    // A word is handed to the RAM when its top lane fills or the stream ends early.
    assign full_o   = (lane_q == TOP_LANE);
    assign flush_o  = accept_i & (full_o | last_i);
    assign wdata_o  = wdata_q;
    assign byteen_o = byteen_q;

endmodule

// File: rtl/sd_stream_ram_writer.sv
// Streams SD-card bytes into the on-chip RAM as 32-bit little-endian words.
// A start command supplies a base word address and a byte count; the writer
// packs bytes, writes each word once on a RAM clock-enabled cycle, advances the
// address (wrapping at the top of the RAM) and pulses done at the end.
// LEN_W must be ADDR_W+3 so a single transfer can cover the whole RAM.
module sd_stream_ram_writer
    import sd_ram_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 19
) (
    input  logic                   clk,
    input  logic                   reset,
    sd_stream_ram_writer_if.slave  bus
);

    sd_wr_state_t      state_q;
    logic [ADDR_W-1:0] addr_q;     // address of the word being packed/written
    logic [LEN_W-1:0]  rem_q;      // bytes still to accept
    logic [ADDR_W:0]   words_q;    // RAM writes completed in this transfer

    logic                 accept;
    logic                 last_byte;
    logic                 write_done;
    logic                 pk_full;
    logic                 pk_flush;
    logic [SD_WORD_W-1:0] pk_wdata;
    logic [SD_LANES-1:0]  pk_byteen;

    // A byte moves only while filling; s_valid never gates s_ready.
    assign accept     = (state_q == FILL) & bus.s_valid;
    assign last_byte  = (rem_q == LEN_W'(1));
    assign write_done = (state_q == WRITE) & bus.mem_clken;

    sd_byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .accept_i (accept),
        .data_i   (bus.s_data),
        .last_i   (last_byte),
        .clear_i  (write_done),
        .full_o   (pk_full),
        .flush_o  (pk_flush),
        .wdata_o  (pk_wdata),
        .byteen_o (pk_byteen)
    );

    // Control FSM together with the address, remaining-byte and write counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            words_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        addr_q  <= bus.base_addr;
                        rem_q   <= bus.byte_len;
                        words_q <= '0;
                        state_q <= (bus.byte_len == '0) ? DONE : FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        rem_q <= rem_q - LEN_W'(1);
                        if (pk_flush) begin
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    // Hold the write until the RAM is clocked, then count it once.
                    if (bus.mem_clken) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        words_q <= words_q + (ADDR_W+1)'(1);
                        state_q <= (rem_q == '0) ? DONE : FILL;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake and status flags decode straight from the state register.
    assign bus.s_ready        = (state_q == FILL);
    assign bus.mem_chipselect = (state_q == WRITE);
    assign bus.mem_write      = (state_q == WRITE);
    assign bus.busy           = (state_q != IDLE);
    assign bus.done           = (state_q == DONE);

    // RAM bus: address is only meaningful during WRITE, otherwise it shows the
    // next address to be written.
    assign bus.mem_address    = addr_q;
    assign bus.mem_byteenable = pk_byteen;
    assign bus.mem_writedata  = pk_wdata;

    assign bus.words_written  = words_q;
    assign bus.dbg_state      = state_q;

    // The top-lane flag only matters inside the packer's flush decision.
    logic unused_full;
    assign unused_full = pk_full;

endmodule
